// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Types and constants shared by the fetch unit and the control
//               unit: fetch FSM state encoding, the canonical NOP, and RV32
//               instruction-field bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Fetch unit FSM states
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } ifu_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int INSTR_W = 32;

  // RV32 field positions consumed by the decoder
  localparam int OP_LSB       = 0;
  localparam int OP_MSB       = 6;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT7_5_BIT = 30;

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fifo
// Description : Synchronous FIFO holding fetched {instruction, pc} pairs.
//               The head entry is read straight from the storage registers.
//               Flush has priority over push and pop. Push while full is
//               accepted when a pop happens in the same cycle.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               flush           - discard all entries
//               push, push_data - write an entry
//               pop             - remove the head entry
//               head            - current head entry (valid when !empty)
//               full, empty     - status flags
//               count           - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Holds the PC, issues in-order word fetches over a valid/ready
//               request channel, buffers responses in ifu_fifo and presents
//               the head instruction with pre-sliced decoder fields. A
//               redirect from execute flushes the buffer and discards every
//               response still in flight.
// Config      : IFU_MISALIGN_CHK_EN - when defined, a redirect target with
//               non-zero low bits sets sticky fetch_misalign and halts fetch
//               once in-flight responses have drained.
// Ports       : clk, rst                     - clock, async active-high reset
//               imem_req_valid/ready/addr    - fetch request channel
//               imem_rsp_valid/data          - in-order fetch responses
//               redirect_valid/pc            - taken branch/jump target
//               ins_valid/ready/data/pc      - head instruction to decoder
//               op, funct3, funct7_5         - decoder fields of ins_data
//               fetch_misalign               - sticky misaligned-target flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [31:0]     ins_data,
  output logic [XLEN-1:0] ins_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7_5,
  output logic            fetch_misalign
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = INSTR_W + XLEN;

  ifu_state_t       state, state_n;
  logic [XLEN-1:0]  pc, pc_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [CNT_W-1:0] drop, drop_n;
  logic [CNT_W-1:0] out_adj;
  logic             active;

  logic             req_fire;
  logic             rsp_any;
  logic [XLEN-1:0]  rsp_pc;

  logic             fifo_flush;
  logic             fifo_push;
  logic             fifo_pop;
  logic [FW-1:0]    fifo_head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo_full;

`ifdef IFU_MISALIGN_CHK_EN
  logic             misalign, misalign_n;
`else
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // Requests start only in the first cycle after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) active <= 1'b0;
    else     active <= 1'b1;
  end

  assign imem_req_valid = active && (state == FETCH) &&
                          (({1'b0, outstanding} + {1'b0, fifo_count}) <
                           (CNT_W+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_any        = imem_rsp_valid && (outstanding != '0);

  // In FETCH all outstanding requests are consecutive words ending just
  // below pc, so the oldest one (the one now answering) is pc - 4*outstanding.
  assign rsp_pc = pc - ({{(XLEN-CNT_W){1'b0}}, outstanding} << 2);

  // Outstanding count after this cycle's request and response handshakes.
  assign out_adj = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_any);

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    outstanding_n = outstanding;
    drop_n        = drop;
    fifo_flush    = 1'b0;
    fifo_push     = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    misalign_n    = misalign;
`endif
    if (state != HALT) begin
      if (redirect_valid) begin
        // Everything in flight, including a request accepted this cycle,
        // belongs to the wrong path; a response arriving now is discarded.
        fifo_flush    = 1'b1;
        pc_n          = {redirect_pc[XLEN-1:2], 2'b00};
        outstanding_n = out_adj;
        drop_n        = out_adj;
        state_n       = (out_adj != '0) ? DRAIN : FETCH;
`ifdef IFU_MISALIGN_CHK_EN
        if (redirect_pc[1:0] != 2'b00) misalign_n = 1'b1;
        if (misalign_n && (out_adj == '0)) state_n = HALT;
`endif
      end else begin
        if (req_fire) pc_n = pc + XLEN'(4);
        outstanding_n = out_adj;
        if (rsp_any) begin
          if (drop != '0) drop_n = drop - CNT_W'(1);
          else            fifo_push = 1'b1;
        end
        if ((state == DRAIN) && (drop_n == '0)) begin
`ifdef IFU_MISALIGN_CHK_EN
          state_n = misalign ? HALT : FETCH;
`else
          state_n = FETCH;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      outstanding <= outstanding_n;
      drop        <= drop_n;
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= misalign_n;
  end
  assign fetch_misalign = misalign;
`else
  assign fetch_misalign = 1'b0;
`endif

  ifu_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ins_valid = (state != HALT) && !fifo_empty;
  assign fifo_pop  = ins_valid && ins_ready;

  // Head outputs read as zero when nothing is presented.
  assign ins_data  = ins_valid ? fifo_head[FW-1:XLEN] : '0;
  assign ins_pc    = ins_valid ? fifo_head[XLEN-1:0]  : '0;
  assign op        = ins_data[OP_MSB:OP_LSB];
  assign funct3    = ins_data[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_5  = ins_data[FUNCT7_5_BIT];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A memory model with
//               random latency answers requests; a scoreboard of requested
//               addresses and expected instruction stream (tagged with a
//               redirect epoch) predicts every output each cycle. Directed
//               parts cover reset, redirect targets, backpressure and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid, ins_ready;
  logic [31:0] ins_data, ins_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5, fetch_misalign;

  logic        wrap_req_valid;
  logic [31:0] wrap_req_addr;
  logic        wrap_ins_valid;
  logic [31:0] wrap_ins_data, wrap_ins_pc;
  logic [6:0]  wrap_op;
  logic [2:0]  wrap_funct3;
  logic        wrap_funct7_5, wrap_misalign;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc),
    .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .fetch_misalign(fetch_misalign)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(wrap_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(wrap_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .ins_valid(wrap_ins_valid), .ins_ready(1'b0),
    .ins_data(wrap_ins_data), .ins_pc(wrap_ins_pc),
    .op(wrap_op), .funct3(wrap_funct3), .funct7_5(wrap_funct7_5),
    .fetch_misalign(wrap_misalign)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ins_t;
  typedef struct { logic [31:0] rpc; logic [31:0] exp_pc; } redir_vec_t;

  mreq_t       mq[$];   // requests accepted by memory, in order
  ins_t        eq[$];   // instructions the decoder should see, in order
  int          epoch, cyc, checks, failures, nfires;
  logic [31:0] mpc;     // address the next request must carry
  int          ready_pct, rsp_pct, ins_pct, redir_pm, min_lat, max_lat;
  bit          force_redir;
  logic [31:0] force_pc;
  logic        obs_rv, obs_iv;
  logic [31:0] obs_ipc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int live_inflight();
    int n = 0;
    foreach (mq[i]) if (mq[i].epoch == epoch) n++;
    return n;
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step();
    bit    exp_rv, fire, pop, rsp, rd;
    int    old_ep;
    mreq_t e;
    ins_t  h;
    @(negedge clk);
    cyc++;
    obs_rv  = imem_req_valid;
    obs_iv  = ins_valid;
    obs_ipc = ins_pc;
    if (imem_req_valid && imem_req_ready) nfires++;

    // No new fetches while wrong-path responses are pending; otherwise one
    // credit per buffered or in-flight word.
    exp_rv = (live_inflight() == mq.size()) && (mq.size() + eq.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, mpc);
    chk("ins_valid", 32'(ins_valid), 32'(eq.size() != 0));
    if (eq.size() != 0) begin
      h = eq[0];
      chk("ins_pc", ins_pc, h.pc);
      chk("ins_data", ins_data, h.data);
      chk("op", 32'(op), 32'(h.data[6:0]));
      chk("funct3", 32'(funct3), 32'(h.data[14:12]));
      chk("funct7_5", 32'(funct7_5), 32'(h.data[30]));
    end
    chk("fetch_misalign", 32'(fetch_misalign), 32'h0);

    imem_req_ready = ($urandom_range(99) < ready_pct);
    ins_ready      = ($urandom_range(99) < ins_pct);
    rsp = (mq.size() != 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mq[0].data : $urandom();
    if (force_redir) begin
      rd          = 1'b1;
      redirect_pc = force_pc;
      force_redir = 1'b0;
    end else begin
      rd          = ($urandom_range(999) < redir_pm);
`ifdef IFU_MISALIGN_CHK_EN
      redirect_pc = $urandom() & 32'hFFFF_FFFC;
`else
      redirect_pc = $urandom();
`endif
    end
    redirect_valid = rd;

    fire   = exp_rv && imem_req_ready;
    pop    = (eq.size() != 0) && ins_ready;
    old_ep = epoch;
    if (rsp) e = mq.pop_front();
    if (rd) begin
      eq.delete();
      epoch++;
    end else begin
      if (pop) h = eq.pop_front();
      if (rsp && e.epoch == epoch) begin
        h.data = e.data;
        h.pc   = e.addr;
        eq.push_back(h);
      end
    end
    if (fire) begin
      e.addr  = mpc;
      e.data  = $urandom();
      e.due   = cyc + int'($urandom_range(max_lat, min_lat));
      e.epoch = old_ep;
      mq.push_back(e);
    end
    if (rd)        mpc = {redirect_pc[31:2], 2'b00};
    else if (fire) mpc = mpc + 32'd4;
  endtask

  initial begin
    redir_vec_t tbl[5];
    bit ok, got;
    tbl[0] = '{32'h0000_0100, 32'h0000_0100};
    tbl[1] = '{32'h0000_0102, 32'h0000_0100};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    tbl[3] = '{32'h0000_0ABC, 32'h0000_0ABC};
    tbl[4] = '{32'h0000_0007, 32'h0000_0004};

    checks = 0; failures = 0; epoch = 0; cyc = 0; nfires = 0; mpc = 32'h0;
    ready_pct = 100; rsp_pct = 100; ins_pct = 100; redir_pm = 0;
    min_lat = 1; max_lat = 1; force_redir = 1'b0; force_pc = 32'h0;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; ins_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_ins_valid", 32'(ins_valid), 32'h0);
    chk("rst_ins_data", ins_data, 32'h0);
    chk("rst_ins_pc", ins_pc, 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_funct3", 32'(funct3), 32'h0);
    chk("rst_funct7_5", 32'(funct7_5), 32'h0);
    chk("rst_misalign", 32'(fetch_misalign), 32'h0);
    chk("rst_wrap_addr", wrap_req_addr, 32'hFFFF_FFFC);
    rst = 1'b0;

    // First request right after release; wrap instance rolls over to 0.
    step();
    chk("first_req_valid", 32'(obs_rv), 32'h1);
    chk("wrap_first_valid", 32'(wrap_req_valid), 32'h1);
    chk("wrap_first_addr", wrap_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_second_valid", 32'(wrap_req_valid), 32'h1);
    chk("wrap_second_addr", wrap_req_addr, 32'h0000_0000);

    // Streaming with a 1-cycle memory
    repeat (30) step();

    // Redirect target table: two requests in flight when redirecting
    for (int i = 0; i < 5; i++) begin
`ifdef IFU_MISALIGN_CHK_EN
      if (tbl[i].rpc[1:0] != 2'b00) continue;
`endif
      min_lat = 3; max_lat = 3;
      ok = 1'b0;
      for (int k = 0; k < 30 && !ok; k++) begin
        step();
        ok = (mq.size() == 2) && (live_inflight() == 2);
      end
      chk("redir_setup_two_inflight", 32'(ok), 32'h1);
      force_redir = 1'b1;
      force_pc    = tbl[i].rpc;
      step();
      step();
      chk("redir_ins_valid_falls", 32'(obs_iv), 32'h0);
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        step();
        got = obs_iv;
      end
      chk("redir_first_pc", got ? obs_ipc : 32'hDEAD_BEEF, tbl[i].exp_pc);
    end

    // Backpressure: exactly DEPTH requests, resume one cycle after first pop
    min_lat = 1; max_lat = 1; ins_pct = 0;
    force_redir = 1'b1; force_pc = 32'h0000_0200;
    step();
    nfires = 0;
    repeat (12) step();
    chk("bp_fire_count", nfires, DEPTH);
    chk("bp_req_stalled", 32'(obs_rv), 32'h0);
    ins_pct = 100;
    step();
    chk("bp_pop_cycle_no_req", 32'(obs_rv), 32'h0);
    step();
    chk("bp_resume", 32'(obs_rv), 32'h1);

    // Randomized traffic
    ready_pct = 70; rsp_pct = 70; ins_pct = 60; redir_pm = 30;
    min_lat = 1; max_lat = 4;
    repeat (3000) step();

`ifdef IFU_MISALIGN_CHK_EN
    ready_pct = 0; rsp_pct = 100; redir_pm = 0;
    repeat (10) step();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; ins_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk("mis_flag", 32'(fetch_misalign), 32'h1);
    chk("mis_no_req", 32'(imem_req_valid), 32'h0);
    chk("mis_no_ins", 32'(ins_valid), 32'h0);
    repeat (5) @(negedge clk);
    chk("mis_flag_sticky", 32'(fetch_misalign), 32'h1);
    chk("mis_halted", 32'(imem_req_valid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
